dm_sba_axil_master: RTL and testbench

Converts the debug module's system-bus-access host port (req/gnt/r_valid handshake) into a single-outstanding AXI4-Lite master. It sits directly downstream of the debug module's host port and upstream of the SoC AXI-Lite interconnect, so the external debugger can read and write system memory and peripherals. It issues exactly one AXI transaction per granted request and returns one `r_valid_o` pulse per transaction, for both reads and writes.

---
 rtl/dm_axil_pkg.sv | 27 ++
 rtl/dm_sba_axil_master.sv | 153 +++++++++++++++
 tb/tb_dm_sba_axil_master.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_axil_pkg.sv
// Shared types for the debug-module SBA to AXI4-Lite bridge.
package dm_axil_pkg;

    localparam int AxiLiteDataWidth = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RESP
    } sba_axil_state_e;

    // SLVERR and DECERR both map to a bus error on the debug side.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/dm_sba_axil_master.sv
// Single-outstanding AXI4-Lite master behind the debug module's SBA host port.
// One AXI transaction per grant, one r_valid_o pulse per transaction.
module dm_sba_axil_master
    import dm_axil_pkg::*;
#(
    parameter int          BusWidth = AxiLiteDataWidth,
    parameter logic [2:0]  AxProt   = 3'b010
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  r_err_o,

    output logic [BusWidth-1:0]   m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [BusWidth-1:0]   m_axi_wdata,
    output logic [BusWidth/8-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [BusWidth-1:0]   m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [BusWidth-1:0]   m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    sba_axil_state_e       state;
    logic [BusWidth-1:0]   add_q;
    logic [BusWidth-1:0]   wdata_q;
    logic [BusWidth/8-1:0] be_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_fin;
    logic                  w_fin;

    assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

    // The pulse cycle lands back in IDLE; holding off the grant there keeps
    // the response and the next acceptance in separate cycles.
    assign gnt_o = req_i && (state == IDLE) && !r_valid_o;

    assign m_axi_awaddr = add_q;
    assign m_axi_araddr = add_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = be_q;
    assign m_axi_awprot = AxProt;
    assign m_axi_arprot = AxProt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            add_q         <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            r_valid_o     <= 1'b0;
            r_rdata_o     <= '0;
            r_err_o       <= 1'b0;
        end else begin
            r_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_o) begin
                        add_q   <= add_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (we_i) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
                // AW and W retire independently, in either order.
                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        r_rdata_o    <= '0;
                        r_err_o      <= resp_is_err(m_axi_bresp);
                        state        <= RESP;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        r_rdata_o    <= m_axi_rdata;
                        r_err_o      <= resp_is_err(m_axi_rresp);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    r_valid_o <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_sba_axil_master.sv
// Bench for dm_sba_axil_master: AXI-Lite slave model with stall knobs, a
// response scoreboard, a directed vector table and multi-cycle corner cases.
module tb_dm_sba_axil_master;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i = 1'b0;
    logic [31:0] add_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, r_valid_o, r_err_o;
    logic [31:0] r_rdata_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic [31:0] m_axi_rdata = '0;

    always #5 clk = ~clk;

    dm_sba_axil_master dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, resp_cnt = 0, grant_cnt = 0;

    // slave knobs
    bit          rnd = 1'b0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  cur_resp = '0;
    logic [31:0] cur_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ready_ok(input int cnt, input int w);
        if (rnd) return $urandom_range(0, 3) != 0;
        return cnt >= w;
    endfunction

    // Slave model plus response monitor; readies are only raised while the
    // matching valid is seen, so a raised ready means a handshake next edge.
    bit          aw_got = 0, w_got = 0, ar_got = 0;
    bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [31:0] aw_prev, w_prev, ar_prev;
    logic [3:0]  ws_prev;

    always @(negedge clk) begin
        if (!rst_ni) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            if (m_axi_awready) aw_got = 1;
            if (m_axi_wready)  w_got = 1;
            if (m_axi_arready) ar_got = 1;
            m_axi_bvalid = 0;
            m_axi_rvalid = 0;

            if (aw_pend) begin
                check("aw_held", 32'(m_axi_awvalid), 32'd1);
                check("aw_stable", m_axi_awaddr, aw_prev);
            end
            if (w_pend) begin
                check("w_held", 32'(m_axi_wvalid), 32'd1);
                check("w_stable", m_axi_wdata, w_prev);
                check("wstrb_stable", 32'(m_axi_wstrb), 32'(ws_prev));
            end
            if (ar_pend) begin
                check("ar_held", 32'(m_axi_arvalid), 32'd1);
                check("ar_stable", m_axi_araddr, ar_prev);
            end

            m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (ready_ok(aw_cnt, aw_wait)) begin
                    m_axi_awready = 1; aw_cnt = 0;
                    check("aw_txn", 32'(sb.size() > 0 && sb[0].we), 32'd1);
                    if (sb.size() > 0) check("awaddr", m_axi_awaddr, sb[0].addr);
                    check("awprot", 32'(m_axi_awprot), 32'd2);
                end else aw_cnt++;
            end
            aw_pend = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;

            m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (ready_ok(w_cnt, w_wait)) begin
                    m_axi_wready = 1; w_cnt = 0;
                    check("w_txn", 32'(sb.size() > 0 && sb[0].we), 32'd1);
                    if (sb.size() > 0) begin
                        check("wdata", m_axi_wdata, sb[0].wdata);
                        check("wstrb", 32'(m_axi_wstrb), 32'(sb[0].be));
                    end
                end else w_cnt++;
            end
            w_pend = m_axi_wvalid && !m_axi_wready; w_prev = m_axi_wdata; ws_prev = m_axi_wstrb;

            m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (ready_ok(ar_cnt, ar_wait)) begin
                    m_axi_arready = 1; ar_cnt = 0;
                    check("ar_txn", 32'(sb.size() > 0 && !sb[0].we), 32'd1);
                    if (sb.size() > 0) check("araddr", m_axi_araddr, sb[0].addr);
                    check("arprot", 32'(m_axi_arprot), 32'd2);
                end else ar_cnt++;
            end
            ar_pend = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;

            if (aw_got && w_got && m_axi_bready) begin
                if (ready_ok(b_cnt, b_wait)) begin
                    m_axi_bvalid = 1; m_axi_bresp = cur_resp;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (ar_got && m_axi_rready) begin
                if (ready_ok(r_cnt, r_wait)) begin
                    m_axi_rvalid = 1; m_axi_rresp = cur_resp; m_axi_rdata = cur_rdata;
                    ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end

            if (r_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("r_rdata", r_rdata_o, e.rdata);
                    check("r_err", 32'(r_err_o), 32'(e.err));
                    resp_cnt++;
                end
            end
        end
    end

    // Enters and leaves one time unit after a rising edge; on return the
    // grant has been taken and req_i is low in the following cycle.
    task automatic issue(input vec_t v);
        int   n;
        exp_t e;
        cur_resp = v.resp; cur_rdata = v.rdata;
        req_i = 1; we_i = v.we; add_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        #1;
        n = 0;
        while (!gnt_o && n < 100) begin @(posedge clk); #2; n++; end
        check("grant_seen", 32'(gnt_o), 32'd1);
        if (gnt_o) begin
            e = '{v.we, v.addr, v.wdata, v.be, v.exp_rdata, v.exp_err};
            sb.push_back(e);
            grant_cnt++;
        end
        @(posedge clk); #1;
        req_i = 0;
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (resp_cnt < target && n < 1000) begin @(posedge clk); #1; n++; end
        check("resp_arrived", 32'(resp_cnt >= target), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int   base, ng, n;
        int   gc[3];
        bit   seen;
        vec_t v;

        vecs[0] = '{1'b0, 32'h8000_0010, 32'h0,          4'h0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_0000, 32'h1234_5678,  4'h3, 2'b00, 32'h5555_5555, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_0000, 32'hCAFE_F00D,  4'hF, 2'b11, 32'h0,         32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_0004, 32'h0,          4'h0, 2'b10, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0020, 32'hA5A5_A5A5,  4'h0, 2'b00, 32'h0,         32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h8000_0003, 32'h0,          4'h0, 2'b01, 32'h0123_4567, 32'h0123_4567, 1'b0};
        vecs[6] = '{1'b1, 32'h4000_0001, 32'h8765_4321,  4'hF, 2'b10, 32'h0,         32'h0,         1'b1};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

        rst_ni = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt_rvalid", {30'b0, gnt_o, r_valid_o}, 32'd0);
        check("rst_rdata", r_rdata_o, 32'd0);
        check("rst_err", 32'(r_err_o), 32'd0);
        check("rst_valids_readies",
              32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
        check("rst_addr", m_axi_awaddr | m_axi_araddr, 32'd0);
        check("rst_wdata_wstrb", m_axi_wdata | 32'(m_axi_wstrb), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1;
        @(posedge clk); #1;

        // Zero-wait read: arvalid in cycle 1, pulse exactly in cycle 4.
        issue(vecs[0]);
        check("rd_arvalid_c1", 32'(m_axi_arvalid), 32'd1);
        check("rd_araddr_c1", m_axi_araddr, 32'h8000_0010);
        @(posedge clk); #1;
        check("rd_no_pulse_c2", 32'(r_valid_o), 32'd0);
        @(posedge clk); #1;
        check("rd_no_pulse_c3", 32'(r_valid_o), 32'd0);
        @(posedge clk); #1;
        check("rd_pulse_c4", 32'(r_valid_o), 32'd1);
        check("rd_gnt_blocked_c4", 32'(gnt_o), 32'd0);
        @(posedge clk); #1;
        check("rd_pulse_one_cycle", 32'(r_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rdata_holds", r_rdata_o, 32'hDEAD_BEEF);

        for (int i = 0; i < 8; i++) begin
            base = resp_cnt;
            issue(vecs[i]);
            wait_resp(base + 1);
        end

        // W completes three cycles ahead of AW.
        aw_wait = 3;
        base = resp_cnt;
        issue(vecs[1]);
        check("wr_both_valid_c1", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd3);
        @(posedge clk); #1;
        check("wr_w_dropped_c2", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd2);
        @(posedge clk); #1;
        check("wr_aw_held_c3", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd2);
        check("wr_wstrb", 32'(m_axi_wstrb), 32'd3);
        wait_resp(base + 1);
        aw_wait = 0;
        check("wr_rdata_zero", r_rdata_o, 32'd0);

        // Request held across three reads: grants five cycles apart, in order.
        req_i = 1; we_i = 0; add_i = 32'h8000_1000; cur_resp = 2'b00;
        base = resp_cnt; ng = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            #1;
            if (gnt_o) begin
                exp_t e;
                cur_rdata = 32'h100 + 32'(ng);
                e = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, cur_rdata, 1'b0};
                sb.push_back(e);
                grant_cnt++;
                gc[ng] = c;
                ng++;
            end
            @(posedge clk); #1;
        end
        req_i = 0;
        check("b2b_grants", 32'(ng), 32'd3);
        check("b2b_spacing_01", 32'(gc[1] - gc[0]), 32'd5);
        check("b2b_spacing_12", 32'(gc[2] - gc[1]), 32'd5);
        wait_resp(base + 3);

        // Reset while waiting for rvalid.
        r_wait = 20;
        issue('{1'b0, 32'h8000_0040, 32'h0, 4'h0, 2'b00, 32'h7777_7777, 32'h7777_7777, 1'b0});
        n = 0;
        while (!m_axi_rready && n < 20) begin @(posedge clk); #1; n++; end
        check("reached_rd_resp", 32'(m_axi_rready), 32'd1);
        #2;
        rst_ni = 0;
        #1;
        check("async_rst_valids",
              32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
        check("async_rst_rvalid", 32'(r_valid_o), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1;
        r_wait = 0;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (r_valid_o) seen = 1; end
        check("no_pulse_after_rst", 32'(seen), 32'd0);
        base = resp_cnt;
        issue('{1'b0, 32'h8000_0044, 32'h0, 4'h0, 2'b00, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0});
        wait_resp(base + 1);

        // Random stalls on every slave channel.
        rnd = 1;
        base = grant_cnt - resp_cnt;
        for (int i = 0; i < 1000; i++) begin
            n = resp_cnt;
            v.we = 1'(($urandom_range(0, 1)));
            v.addr = $urandom; v.wdata = $urandom; v.be = 4'($urandom_range(0, 15));
            v.resp = 2'($urandom_range(0, 3)); v.rdata = $urandom;
            v.exp_rdata = v.we ? 32'h0 : v.rdata;
            v.exp_err = v.resp[1];
            issue(v);
            wait_resp(n + 1);
        end
        rnd = 0;
        repeat (4) @(posedge clk);
        #1;
        check("grants_eq_resps", 32'(grant_cnt - resp_cnt), 32'(base));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
